imem_axi_rd_resp: RTL and testbench
===================================

IMEM_AXI_RD_RESP -- requirements
Module: imem_axi_rd_resp

Interface
REQ-001 SHALL have parameter MemWords, default 4096; 64-bit words backing the responder (power of two).
REQ-002 SHALL have parameter BaseAddr, default 32'h0000_0000; byte address of word 0.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have AR ports: axi_arid (input, AxiIdWidth), axi_araddr (input, 32), axi_arlen (input, 8), axi_arsize (input, 3), axi_arburst (input, 2), axi_arvalid (input, 1) and axi_arready (output, 1); arlock, arcache, arprot, arqos and arregion SHALL be accepted as inputs and ignored.
REQ-006 SHALL have R ports: axi_rid (output, AxiIdWidth), axi_rdata (output, 64), axi_rresp (output, 2), axi_rlast (output, 1), axi_rvalid (output, 1) and axi_rready (input, 1).
REQ-007 SHALL have SRAM port mem_rden (output, 1), mem_addr (output, $clog2(MemWords)) and mem_rdata (input, 64), with exactly 1-cycle read latency.

Function
REQ-008 SHALL implement FSM IDLE/BURST: IDLE asserts axi_arready; an AR handshake latches id, addr, len, size and burst and moves to BURST; BURST deasserts axi_arready.
REQ-009 SHALL return arlen+1 beats per burst (1..256), with axi_rid equal to the latched id on every beat.
REQ-010 SHALL compute beat addresses with INCR adding (1<<arsize) per beat and FIXED repeating the start address, addition being 32-bit wrapping.
REQ-011 SHALL treat WRAP (2'b10) and reserved (2'b11) bursts as FIXED and respond SLVERR (2'b10) on every beat.
REQ-012 SHALL drive mem_addr = (beat_addr - BaseAddr) >> 3 and return the full 64-bit word; narrow sizes receive the whole word.
REQ-013 SHALL respond DECERR (2'b11) with axi_rdata = 0 and no mem_rden for any beat whose address lies outside [BaseAddr, BaseAddr + 8*MemWords); other beats SHALL respond OKAY.
REQ-014 SHALL assert mem_rden for a beat only when the 2-entry output skid buffer will have a free slot the next cycle, so no SRAM data is ever dropped.
REQ-015 SHALL give rvalid-to-AR latency of 2 cycles: AR handshake at edge T, first beat valid after edge T+2.
REQ-016 SHALL sustain 1 beat/cycle while axi_rready = 1.
REQ-017 SHALL keep axi_rid, axi_rdata, axi_rresp and axi_rlast stable while axi_rvalid = 1 and axi_rready = 0.
REQ-018 SHALL never drop axi_rvalid without a handshake.
REQ-019 SHALL assert axi_rlast only on beat arlen.
REQ-020 SHALL return to IDLE on the rlast handshake, so that axi_arready rises the following cycle.
REQ-021 SHALL, when arlen = 0, send a single beat with rlast = 1.
REQ-022 SHALL, when an INCR address crosses the top of the window mid-burst, give DECERR on the remaining beats while still completing all arlen+1 beats.

Reset
REQ-023 SHALL, on rst_n low at any time, immediately clear state to IDLE, empty the skid buffer and force axi_arready = 0, axi_rvalid = 0, axi_rlast = 0, axi_rresp = 0, axi_rid = 0, axi_rdata = 0 and mem_rden = 0.
REQ-024 SHALL raise axi_arready the first cycle after rst_n deasserts; an in-flight burst is discarded.

Structure
REQ-025 SHALL take AxiIdWidth, the burst encodings (FIXED, INCR, WRAP) and the resp encodings (OKAY, EXOKAY, SLVERR, DECERR) from shared package instr_defs; they SHALL not be redefined locally.
REQ-026 SHALL place the skid buffer in one sub-module, axi_r_skid (2-entry, valid/ready, width AxiIdWidth+64+2+1).
REQ-027 SHALL keep the SRAM model outside the block.

Verification
REQ-028 SHALL cover a single beat: araddr 0x10, arlen 0, INCR, rready 1 -> one beat of word[2], OKAY, rlast=1, rvalid two cycles after the AR handshake.
REQ-029 SHALL cover a full-rate burst: araddr 0x0, arlen 15, arsize 3, INCR, rready 1 -> words 0..15 on 16 consecutive cycles, rlast on beat 15, arready high again the next cycle.
REQ-030 SHALL cover backpressure: the same burst with rready toggling 1/0 randomly -> data order is intact, no beat is lost or duplicated, and outputs are stable during stalls.
REQ-031 SHALL cover window crossing: MemWords 4, araddr 0x18, arlen 2 -> beat0 word[3] OKAY, then beats 1 and 2 DECERR with rdata 0, rlast on beat 2.
REQ-032 SHALL cover WRAP: arburst 2'b10, arlen 3 -> 4 beats, all SLVERR, rlast on beat 3.
REQ-033 SHALL cover reset mid-burst: rst_n pulsed low at beat 5 of 16 -> rvalid 0 immediately, arready 1 one cycle after release, and a new burst served correctly.

Source files
------------

// File: rtl/imem_axi_rd_resp_pkg.sv
// Local types and helpers for the instruction-memory AXI read responder.
package imem_axi_rd_resp_pkg;
  import instr_defs::*;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // One R-channel beat as it sits in the output skid buffer.
  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [63:0]           data;
    logic [1:0]            resp;
    logic                  last;
  } r_beat_t;

  localparam int RBeatW = $bits(r_beat_t);

  // Address increment between beats; everything except INCR holds the start address.
  function automatic logic [31:0] beat_step(input logic [2:0] size, input logic [1:0] burst);
    return (burst == BURST_INCR) ? (32'd1 << size) : 32'd0;
  endfunction

  // Only FIXED and INCR are served normally; WRAP and the reserved code get SLVERR.
  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/instr_defs.sv
// Shared AXI encodings and widths used across the instruction-memory blocks.
package instr_defs;

  localparam int AxiIdWidth = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/imem_axi_rd_resp_if.sv
// AXI read address / read data channels between a master and the IMEM responder.
interface imem_axi_rd_resp_if;
  import instr_defs::*;

  logic [AxiIdWidth-1:0] axi_arid;
  logic [31:0]           axi_araddr;
  logic [7:0]            axi_arlen;
  logic [2:0]            axi_arsize;
  logic [1:0]            axi_arburst;
  logic                  axi_arlock;
  logic [3:0]            axi_arcache;
  logic [2:0]            axi_arprot;
  logic [3:0]            axi_arqos;
  logic [3:0]            axi_arregion;
  logic                  axi_arvalid;
  logic                  axi_arready;

  logic [AxiIdWidth-1:0] axi_rid;
  logic [63:0]           axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_arvalid,
    input  axi_arready,
    input  axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    output axi_rready
  );

  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arlock,
           axi_arcache, axi_arprot, axi_arqos, axi_arregion, axi_arvalid,
    output axi_arready,
    output axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
    input  axi_rready
  );

endinterface

// File: rtl/imem_axi_rd_resp_skid.sv
// Two-entry output buffer for R beats. The head entry drives the outputs straight
// from flops, so the beat stays stable while the consumer stalls. The producer
// is credit-managed through count_o, so a push never arrives when both slots are full.
module axi_r_skid #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] slot_q [2];
  logic             wr_q;
  logic             rd_q;
  logic [1:0]       cnt_q;
  logic             push;
  logic             pop;

  assign push        = in_valid_i && (cnt_q != 2'd2);
  assign pop         = out_valid_o && out_ready_i;
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = slot_q[rd_q];
  assign count_o     = cnt_q;

  // Circular two-slot storage with occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_q] <= in_data_i;
        wr_q         <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/imem_axi_rd_resp.sv
// AXI4 read-only responder in front of a 1-cycle-latency 64-bit SRAM.
//
//   state    | meaning
//   ST_IDLE  | arready high, waiting for an AR handshake
//   ST_BURST | issuing beats to the SRAM, waiting for the rlast handshake
//
// Beats flow: issue (mem_rden) -> one pipeline flop while the SRAM reads ->
// skid buffer -> R channel. A beat is issued only if the skid buffer is
// guaranteed a free slot when its data lands.
module imem_axi_rd_resp
  import instr_defs::*;
  import imem_axi_rd_resp_pkg::*;
#(
  parameter int          MemWords = 4096,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  imem_axi_rd_resp_if.slave           axi,
  output logic                        mem_rden,
  output logic [$clog2(MemWords)-1:0] mem_addr,
  input  logic [63:0]                 mem_rdata
);

  localparam int          AddrW    = $clog2(MemWords);
  localparam logic [32:0] WinBytes = 33'(MemWords) << 3;

  state_e                state_q;
  logic                  arready_q;
  logic [AxiIdWidth-1:0] id_q;
  logic [31:0]           addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [8:0]            beat_q;

  logic                  p_valid_q;
  logic [AxiIdWidth-1:0] p_id_q;
  logic [1:0]            p_resp_q;
  logic                  p_last_q;
  logic                  p_hit_q;

  logic [31:0] off;
  logic        hit;
  logic [31:0] addr_d;
  logic [1:0]  beat_resp;
  logic        beat_last;
  logic        issue;
  logic [1:0]  skid_cnt;
  logic        skid_valid;
  logic        pop;
  logic        rlast_hs;
  logic [2:0]  occ_next;
  r_beat_t     skid_in;
  r_beat_t     skid_out;

  // Cache/prot/qos/lock/region are accepted and deliberately ignored.
  logic unused_ar_sideband;
  assign unused_ar_sideband = ^{axi.axi_arlock, axi.axi_arcache, axi.axi_arprot,
                                axi.axi_arqos, axi.axi_arregion};

  assign off       = addr_q - BaseAddr;
  assign hit       = {1'b0, off} < WinBytes;
  assign addr_d    = addr_q + beat_step(size_q, burst_q);
  assign beat_last = (beat_q == {1'b0, len_q});
  assign beat_resp = !hit ? RESP_DECERR : (burst_ok(burst_q) ? RESP_OKAY : RESP_SLVERR);

  // Skid occupancy once this edge's push/pop settle; a beat issued now lands one edge later.
  assign pop      = skid_valid && axi.axi_rready;
  assign occ_next = {1'b0, skid_cnt} + {2'b00, p_valid_q} - {2'b00, pop};
  assign issue    = (state_q == ST_BURST) && (beat_q <= {1'b0, len_q}) && (occ_next < 3'd2);
  assign rlast_hs = pop && skid_out.last;

  assign mem_rden = issue && hit;
  assign mem_addr = off[AddrW+2:3];

  // Control FSM: latch the AR request, walk beat addresses, finish on the rlast handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      beat_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arready_q && axi.axi_arvalid) begin
            id_q      <= axi.axi_arid;
            addr_q    <= axi.axi_araddr;
            len_q     <= axi.axi_arlen;
            size_q    <= axi.axi_arsize;
            burst_q   <= axi.axi_arburst;
            beat_q    <= '0;
            state_q   <= ST_BURST;
            arready_q <= 1'b0;
          end else begin
            arready_q <= 1'b1;
          end
        end
        ST_BURST: begin
          if (issue) begin
            beat_q <= beat_q + 9'd1;
            addr_q <= addr_d;
          end
          if (rlast_hs) begin
            state_q   <= ST_IDLE;
            arready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Beat side-band held alongside the SRAM read so it meets its data next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q <= 1'b0;
      p_id_q    <= '0;
      p_resp_q  <= '0;
      p_last_q  <= 1'b0;
      p_hit_q   <= 1'b0;
    end else begin
      p_valid_q <= issue;
      if (issue) begin
        p_id_q   <= id_q;
        p_resp_q <= beat_resp;
        p_last_q <= beat_last;
        p_hit_q  <= hit;
      end
    end
  end

  // Out-of-window beats return zero data instead of whatever the SRAM bus holds.
  always_comb begin
    skid_in      = '0;
    skid_in.id   = p_id_q;
    skid_in.data = p_hit_q ? mem_rdata : 64'd0;
    skid_in.resp = p_resp_q;
    skid_in.last = p_last_q;
  end

  axi_r_skid #(
    .Width(RBeatW)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (p_valid_q),
    .in_data_i  (skid_in),
    .out_valid_o(skid_valid),
    .out_ready_i(axi.axi_rready),
    .out_data_o (skid_out),
    .count_o    (skid_cnt)
  );

  assign axi.axi_arready = arready_q;
  assign axi.axi_rvalid  = skid_valid;
  assign axi.axi_rid     = skid_out.id;
  assign axi.axi_rdata   = skid_out.data;
  assign axi.axi_rresp   = skid_out.resp;
  assign axi.axi_rlast   = skid_out.last;

endmodule

// File: tb/tb_imem_axi_rd_resp.sv
// Bench for imem_axi_rd_resp: three instances with different windows share one
// AR stream and one rready, each checked against an address-arithmetic model.
module tb_imem_axi_rd_resp;
  import instr_defs::*;

  localparam int NDut = 3;
  localparam int MwA  = 4096;
  localparam int MwB  = 4;
  localparam int MwC  = 16;

  int          mw   [NDut] = '{MwA, MwB, MwC};
  logic [31:0] base [NDut] = '{32'h0000_0000, 32'h0000_0000, 32'h8000_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [AxiIdWidth-1:0] arid = '0;
  logic [31:0]           araddr = '0;
  logic [7:0]            arlen = '0;
  logic [2:0]            arsize = '0;
  logic [1:0]            arburst = '0;
  logic                  arvalid = 1'b0;
  logic                  rready = 1'b0;

  logic [63:0] mem [MwA];

  imem_axi_rd_resp_if ifa ();
  imem_axi_rd_resp_if ifb ();
  imem_axi_rd_resp_if ifc ();

  assign ifa.axi_arid = arid;       assign ifb.axi_arid = arid;       assign ifc.axi_arid = arid;
  assign ifa.axi_araddr = araddr;   assign ifb.axi_araddr = araddr;   assign ifc.axi_araddr = araddr;
  assign ifa.axi_arlen = arlen;     assign ifb.axi_arlen = arlen;     assign ifc.axi_arlen = arlen;
  assign ifa.axi_arsize = arsize;   assign ifb.axi_arsize = arsize;   assign ifc.axi_arsize = arsize;
  assign ifa.axi_arburst = arburst; assign ifb.axi_arburst = arburst; assign ifc.axi_arburst = arburst;
  assign ifa.axi_arvalid = arvalid; assign ifb.axi_arvalid = arvalid; assign ifc.axi_arvalid = arvalid;
  assign ifa.axi_rready = rready;   assign ifb.axi_rready = rready;   assign ifc.axi_rready = rready;
  assign ifa.axi_arlock = 1'b0;     assign ifb.axi_arlock = 1'b0;     assign ifc.axi_arlock = 1'b0;
  assign ifa.axi_arcache = 4'h3;    assign ifb.axi_arcache = 4'h3;    assign ifc.axi_arcache = 4'h3;
  assign ifa.axi_arprot = 3'h4;     assign ifb.axi_arprot = 3'h4;     assign ifc.axi_arprot = 3'h4;
  assign ifa.axi_arqos = 4'h0;      assign ifb.axi_arqos = 4'h0;      assign ifc.axi_arqos = 4'h0;
  assign ifa.axi_arregion = 4'h0;   assign ifb.axi_arregion = 4'h0;   assign ifc.axi_arregion = 4'h0;

  logic        rden_a, rden_b, rden_c;
  logic [11:0] maddr_a;
  logic [1:0]  maddr_b;
  logic [3:0]  maddr_c;
  logic [63:0] mrdata_a, mrdata_b, mrdata_c;

  imem_axi_rd_resp #(.MemWords(MwA), .BaseAddr(32'h0000_0000)) u_a (
    .clk(clk), .rst_n(rst_n), .axi(ifa), .mem_rden(rden_a), .mem_addr(maddr_a), .mem_rdata(mrdata_a));
  imem_axi_rd_resp #(.MemWords(MwB), .BaseAddr(32'h0000_0000)) u_b (
    .clk(clk), .rst_n(rst_n), .axi(ifb), .mem_rden(rden_b), .mem_addr(maddr_b), .mem_rdata(mrdata_b));
  imem_axi_rd_resp #(.MemWords(MwC), .BaseAddr(32'h8000_0000)) u_c (
    .clk(clk), .rst_n(rst_n), .axi(ifc), .mem_rden(rden_c), .mem_addr(maddr_c), .mem_rdata(mrdata_c));

  // SRAM models with 1-cycle read latency, all backed by the same word array.
  int rden_cnt_a = 0, rden_cnt_b = 0, rden_cnt_c = 0;
  always @(posedge clk) begin
    if (rden_a) begin mrdata_a <= mem[maddr_a]; rden_cnt_a <= rden_cnt_a + 1; end
    if (rden_b) begin mrdata_b <= mem[maddr_b]; rden_cnt_b <= rden_cnt_b + 1; end
    if (rden_c) begin mrdata_c <= mem[maddr_c]; rden_cnt_c <= rden_cnt_c + 1; end
  end

  logic                  s_rvalid [NDut];
  logic                  s_arready[NDut];
  logic [AxiIdWidth-1:0] s_rid    [NDut];
  logic [63:0]           s_rdata  [NDut];
  logic [1:0]            s_rresp  [NDut];
  logic                  s_rlast  [NDut];
  logic                  s_rden   [NDut];
  assign s_rvalid[0] = ifa.axi_rvalid;  assign s_rvalid[1] = ifb.axi_rvalid;  assign s_rvalid[2] = ifc.axi_rvalid;
  assign s_arready[0] = ifa.axi_arready; assign s_arready[1] = ifb.axi_arready; assign s_arready[2] = ifc.axi_arready;
  assign s_rid[0] = ifa.axi_rid;        assign s_rid[1] = ifb.axi_rid;        assign s_rid[2] = ifc.axi_rid;
  assign s_rdata[0] = ifa.axi_rdata;    assign s_rdata[1] = ifb.axi_rdata;    assign s_rdata[2] = ifc.axi_rdata;
  assign s_rresp[0] = ifa.axi_rresp;    assign s_rresp[1] = ifb.axi_rresp;    assign s_rresp[2] = ifc.axi_rresp;
  assign s_rlast[0] = ifa.axi_rlast;    assign s_rlast[1] = ifb.axi_rlast;    assign s_rlast[2] = ifc.axi_rlast;
  assign s_rden[0] = rden_a;            assign s_rden[1] = rden_b;            assign s_rden[2] = rden_c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: beat i of a burst, from the address rules alone.
  function automatic void model_beat(input int d, input logic [31:0] a, input int i,
                                     input logic [2:0] sz, input logic [1:0] bt,
                                     output logic [63:0] data, output logic [1:0] resp,
                                     output bit hit);
    logic [31:0]    ba;
    logic [31:0]    off;
    longint         win;
    ba   = (bt == 2'b01) ? a + (32'(i) << sz) : a;
    off  = ba - base[d];
    win  = longint'(mw[d]) * 8;
    hit  = longint'(off) < win;
    resp = !hit ? 2'b11 : ((bt >= 2'b10) ? 2'b10 : 2'b00);
    data = hit ? mem[int'(off >> 3)] : 64'd0;
  endfunction

  task automatic check_idle_outputs(input string tag, input logic exp_arready);
    for (int d = 0; d < NDut; d++) begin
      chk($sformatf("%s_d%0d_arready", tag, d), s_arready[d], exp_arready);
      chk($sformatf("%s_d%0d_rvalid", tag, d), s_rvalid[d], 1'b0);
      chk($sformatf("%s_d%0d_rlast", tag, d), s_rlast[d], 1'b0);
      chk($sformatf("%s_d%0d_rresp", tag, d), s_rresp[d], 2'b00);
      chk($sformatf("%s_d%0d_rid", tag, d), s_rid[d], '0);
      chk($sformatf("%s_d%0d_rdata", tag, d), s_rdata[d], 64'd0);
      chk($sformatf("%s_d%0d_rden", tag, d), s_rden[d], 1'b0);
    end
  endtask

  task automatic run_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bt, input bit rand_bp, input int rst_beat);
    int                    k[NDut];
    int                    first[NDut];
    bit                    stall[NDut];
    logic [63:0]           pdata[NDut];
    logic [1:0]            presp[NDut];
    logic                  plast[NDut];
    logic [AxiIdWidth-1:0] pid[NDut];
    logic [AxiIdWidth-1:0] id;
    logic [63:0]           edata;
    logic [1:0]            eresp;
    bit                    ehit;
    int                    idx;
    int                    nhit;
    bit                    done;
    id = AxiIdWidth'($urandom);
    @(negedge clk);
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bt; arvalid = 1'b1;
    rden_cnt_a = 0; rden_cnt_b = 0; rden_cnt_c = 0;
    idx = 0;
    while (!(s_arready[0] && s_arready[1] && s_arready[2]) && idx < 50) begin
      @(negedge clk);
      idx++;
    end
    chk("arready_idle", s_arready[0] & s_arready[1] & s_arready[2], 1'b1);
    @(posedge clk);
    #1 arvalid = 1'b0;
    for (int d = 0; d < NDut; d++) begin
      k[d] = 0; first[d] = -1; stall[d] = 1'b0;
    end
    idx = 0;
    done = 1'b0;
    while (!done && idx < 3000) begin
      @(negedge clk);
      if (rst_beat >= 0 && k[0] == rst_beat) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid", 1'b0);
        rready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("rst_release", 1'b1);
        return;
      end
      rready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int d = 0; d < NDut; d++) begin
        if (stall[d]) begin
          chk($sformatf("d%0d_hold_rvalid", d), s_rvalid[d], 1'b1);
          chk($sformatf("d%0d_hold_rdata", d), s_rdata[d], pdata[d]);
          chk($sformatf("d%0d_hold_rresp", d), s_rresp[d], presp[d]);
          chk($sformatf("d%0d_hold_rlast", d), s_rlast[d], plast[d]);
          chk($sformatf("d%0d_hold_rid", d), s_rid[d], pid[d]);
        end
        stall[d] = 1'b0;
        if (s_rvalid[d] === 1'b1) begin
          if (first[d] < 0) begin
            first[d] = idx;
            chk($sformatf("d%0d_first_latency", d), idx, 2);
            chk($sformatf("d%0d_arready_busy", d), s_arready[d], 1'b0);
          end
          if (k[d] > int'(len)) begin
            chk($sformatf("d%0d_extra_beat", d), k[d], int'(len));
          end else begin
            model_beat(d, a, k[d], sz, bt, edata, eresp, ehit);
            chk($sformatf("d%0d_b%0d_rid", d, k[d]), s_rid[d], id);
            chk($sformatf("d%0d_b%0d_rresp", d, k[d]), s_rresp[d], eresp);
            chk($sformatf("d%0d_b%0d_rlast", d, k[d]), s_rlast[d], k[d] == int'(len));
            if (eresp != 2'b10)
              chk($sformatf("d%0d_b%0d_rdata", d, k[d]), s_rdata[d], edata);
            if (!rand_bp && k[d] == int'(len))
              chk($sformatf("d%0d_last_cycle", d), idx, 2 + int'(len));
          end
          if (rready) begin
            k[d]++;
          end else begin
            stall[d] = 1'b1;
            pdata[d] = s_rdata[d]; presp[d] = s_rresp[d];
            plast[d] = s_rlast[d]; pid[d] = s_rid[d];
          end
        end
      end
      done = (k[0] > int'(len)) && (k[1] > int'(len)) && (k[2] > int'(len));
      idx++;
    end
    chk("burst_complete", done, 1'b1);
    @(negedge clk);
    for (int d = 0; d < NDut; d++) begin
      chk($sformatf("d%0d_arready_after_last", d), s_arready[d], 1'b1);
      chk($sformatf("d%0d_rvalid_after_last", d), s_rvalid[d], 1'b0);
      if (bt <= 2'b01) begin
        nhit = 0;
        for (int i = 0; i <= int'(len); i++) begin
          model_beat(d, a, i, sz, bt, edata, eresp, ehit);
          if (ehit) nhit++;
        end
        chk($sformatf("d%0d_rden_count", d),
            (d == 0) ? rden_cnt_a : ((d == 1) ? rden_cnt_b : rden_cnt_c), nhit);
      end
    end
  endtask

  initial begin
    logic [31:0] ra;
    for (int i = 0; i < MwA; i++) mem[i] = {$urandom, $urandom};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < NDut; d++) chk($sformatf("d%0d_arready_post_reset", d), s_arready[d], 1'b1);

    run_burst(32'h0000_0010, 8'd0,  3'd3, 2'b01, 1'b0, -1);
    run_burst(32'h0000_0000, 8'd15, 3'd3, 2'b01, 1'b0, -1);
    run_burst(32'h0000_0000, 8'd15, 3'd3, 2'b01, 1'b1, -1);
    run_burst(32'h0000_0018, 8'd2,  3'd3, 2'b01, 1'b0, -1);
    run_burst(32'h0000_0020, 8'd3,  3'd3, 2'b10, 1'b0, -1);
    run_burst(32'h0000_0008, 8'd3,  3'd3, 2'b11, 1'b1, -1);
    run_burst(32'h0000_0028, 8'd4,  3'd3, 2'b00, 1'b0, -1);
    run_burst(32'h0000_0000, 8'd15, 3'd3, 2'b01, 1'b0, 5);
    run_burst(32'h0000_0040, 8'd15, 3'd3, 2'b01, 1'b1, -1);
    run_burst(32'h8000_0070, 8'd3,  3'd3, 2'b01, 1'b0, -1);
    run_burst(32'hFFFF_FFF0, 8'd3,  3'd3, 2'b01, 1'b0, -1);
    run_burst(32'h0000_0004, 8'd9,  3'd1, 2'b01, 1'b1, -1);

    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 2))
        0:       ra = 32'($urandom_range(0, 300));
        1:       ra = 32'h7FFF_FFE0 + 32'($urandom_range(0, 200));
        default: ra = 32'h0000_7F00 + 32'($urandom_range(0, 400));
      endcase
      run_burst(ra, 8'($urandom_range(0, 20)), 3'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    run_burst(32'h0000_0100, 8'd255, 3'd3, 2'b01, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
